// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding and line levels.
// The optional parity feature is selected with the UART_TX_PARITY_EN macro.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic UART_IDLE_LVL = 1'b1;
  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO for the UART transmitter.
// Full, empty and level are derived from wrap-bit read/write pointers.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [LVL_W-1:0]  wr_ptr;
  logic [LVL_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // A write to a full FIFO is dropped even when a pop happens in the same cycle.
  assign push  = wr_en & ~full;
  assign pop   = rd_en & ~empty;
  assign level = wr_ptr - rd_ptr;
  assign full  = (level == LVL_W'(FIFO_DEPTH));
  assign empty = (level == '0);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LVL_W'(1);
      if (pop)  rd_ptr <= rd_ptr + LVL_W'(1);
    end
  end

  // NOTE: storage has no reset; clearing the pointers empties the FIFO and
  // keeps the array a plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: write FIFO, 1/2 stop bits, back-to-back frames.
// Define UART_TX_PARITY_EN to build the optional parity bit and PARITY state.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              RSTn,
  input  logic              clk_uart,
  input  logic [DATA_W-1:0] data,
  input  logic              tx_en,
  input  logic              stop2,
  input  logic              parity_en,
  input  logic              parity_odd,
  output logic              TXD,
  output logic              bps_en,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level,
  output logic              busy,
  output logic              overflow
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic              txd_q, txd_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic              stopcnt_q, stopcnt_d;
  logic              stop2_q, stop2_d;
  logic              load;
  logic [DATA_W-1:0] fifo_data;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
`else
  logic unused_parity;
  assign unused_parity = parity_en ^ parity_odd;
`endif

  uart_tx_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH),
    .LVL_W     (LVL_W)
  ) u_fifo (
    .clk    (clk),
    .RSTn   (RSTn),
    .wr_en  (tx_en),
    .wr_data(data),
    .rd_en  (load),
    .rd_data(fifo_data),
    .full   (full),
    .empty  (empty),
    .level  (level)
  );

  assign TXD      = txd_q;
  assign busy     = (state_q != IDLE);
  assign bps_en   = busy | ~empty;
  assign overflow = tx_en & full;

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    txd_d     = txd_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    stopcnt_d = stopcnt_q;
    stop2_d   = stop2_q;
    load      = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif

    if (clk_uart) begin
      case (state_q)
        IDLE: begin
          if (!empty) load = 1'b1;
        end
        START: begin
          txd_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          state_d = DATA;
        end
        DATA: begin
          if (bitcnt_q < LAST_BIT) begin
            txd_d    = shreg_q[0];
            shreg_d  = shreg_q >> 1;
            bitcnt_d = bitcnt_q + 3'd1;
          end
`ifdef UART_TX_PARITY_EN
          else if (par_en_q) begin
            txd_d   = par_bit_q;
            state_d = PARITY;
          end
`endif
          else begin
            txd_d     = STOP_BIT;
            stopcnt_d = 1'b0;
            state_d   = STOP;
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          txd_d     = STOP_BIT;
          stopcnt_d = 1'b0;
          state_d   = STOP;
        end
`endif
        STOP: begin
          if (stop2_q && !stopcnt_q) begin
            stopcnt_d = 1'b1;
          end else if (!empty) begin
            load = 1'b1;
          end else begin
            txd_d   = UART_IDLE_LVL;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Frame start, shared by IDLE and the back-to-back path out of STOP.
    if (load) begin
      txd_d    = START_BIT;
      shreg_d  = fifo_data;
      bitcnt_d = '0;
      stop2_d  = stop2;
      state_d  = START;
`ifdef UART_TX_PARITY_EN
      par_en_d  = parity_en;
      par_bit_d = (^fifo_data) ^ parity_odd;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      state_q   <= IDLE;
      txd_q     <= UART_IDLE_LVL;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      stopcnt_q <= 1'b0;
      stop2_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      txd_q     <= txd_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      stopcnt_q <= stopcnt_d;
      stop2_q   <= stop2_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed self-checking bench for uart_tx_param (8-bit instance plus a 5-bit instance).
// Parity expectations follow UART_TX_PARITY_EN as defined for the build.
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       RSTn = 1'b0;
  logic       clk_uart = 1'b0;
  logic [7:0] data = '0;
  logic       tx_en = 1'b0;
  logic       stop2 = 1'b0;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       TXD, bps_en, full, empty, busy, overflow;
  logic [4:0] level;

  logic [4:0] data5 = '0;
  logic       tx_en5 = 1'b0;
  logic       TXD5, bps_en5, full5, empty5, busy5, overflow5;
  logic [4:0] level5;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_W(8), .FIFO_DEPTH(16)) dut (
    .clk(clk), .RSTn(RSTn), .clk_uart(clk_uart), .data(data), .tx_en(tx_en),
    .stop2(stop2), .parity_en(parity_en), .parity_odd(parity_odd),
    .TXD(TXD), .bps_en(bps_en), .full(full), .empty(empty), .level(level),
    .busy(busy), .overflow(overflow)
  );

  uart_tx_param #(.DATA_W(5), .FIFO_DEPTH(16)) dut5 (
    .clk(clk), .RSTn(RSTn), .clk_uart(clk_uart), .data(data5), .tx_en(tx_en5),
    .stop2(stop2), .parity_en(parity_en), .parity_odd(parity_odd),
    .TXD(TXD5), .bps_en(bps_en5), .full(full5), .empty(empty5), .level(level5),
    .busy(busy5), .overflow(overflow5)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge; inputs change and outputs are sampled here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    clk_uart = 1'b1;
    cyc();
    clk_uart = 1'b0;
  endtask

  task automatic write8(input logic [7:0] d);
    data  = d;
    tx_en = 1'b1;
    cyc();
    tx_en = 1'b0;
  endtask

  // vec[i] is the expected line level after tick i of the frame (bit 0 = start bit).
  task automatic send_frame(input string tag, input logic [31:0] vec, input int n, input int first, input bit use5);
    for (int i = first; i < n; i++) begin
      tick();
      check($sformatf("%s bit%0d", tag, i), use5 ? TXD5 : TXD, vec[i]);
      cyc();
      check($sformatf("%s hold%0d", tag, i), use5 ? TXD5 : TXD, vec[i]);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, busy, 1'b0);
    check({tag, " bps_en"}, bps_en, 1'b0);
    check({tag, " TXD"}, TXD, 1'b1);
  endtask

  initial begin
    logic [7:0] byte_v;

    // Reset
    repeat (3) cyc();
    check("rst TXD", TXD, 1'b1);
    check("rst bps_en", bps_en, 1'b0);
    check("rst full", full, 1'b0);
    check("rst empty", empty, 1'b1);
    check("rst level", level, 5'd0);
    check("rst busy", busy, 1'b0);
    check("rst overflow", overflow, 1'b0);
    check("rst TXD5", TXD5, 1'b1);
    RSTn = 1'b1;
    cyc();

    // Tick with empty FIFO is ignored
    tick();
    check_idle("idle tick");

    // 8'hA5, one stop bit; stop2 raised mid-frame must not stretch this frame
    write8(8'hA5);
    check("A5 empty", empty, 1'b0);
    check("A5 level", level, 5'd1);
    check("A5 bps_en", bps_en, 1'b1);
    check("A5 busy pre", busy, 1'b0);
    check("A5 TXD pre", TXD, 1'b1);
    tick();
    check("A5 start", TXD, 1'b0);
    check("A5 busy", busy, 1'b1);
    check("A5 popped", level, 5'd0);
    stop2 = 1'b1;
    cyc();
    send_frame("A5", {22'd0, 1'b1, 8'hA5, 1'b0}, 10, 1, 1'b0);
    tick();
    check_idle("A5 end");

    // 8'h3C, 8'hC3 back-to-back with two stop bits
    write8(8'h3C);
    write8(8'hC3);
    check("b2b level", level, 5'd2);
    send_frame("b2b", {10'd0, 2'b11, 8'hC3, 1'b0, 2'b11, 8'h3C, 1'b0}, 22, 0, 1'b0);
    tick();
    check_idle("b2b end");

    // 8'h07 with parity requested, even then odd
    stop2      = 1'b0;
    parity_en  = 1'b1;
    parity_odd = 1'b0;
    write8(8'h07);
`ifdef UART_TX_PARITY_EN
    send_frame("par even", {21'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 0, 1'b0);
`else
    send_frame("par even", {22'd0, 1'b1, 8'h07, 1'b0}, 10, 0, 1'b0);
`endif
    tick();
    check_idle("par even end");
    parity_odd = 1'b1;
    write8(8'h07);
`ifdef UART_TX_PARITY_EN
    send_frame("par odd", {21'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 0, 1'b0);
`else
    send_frame("par odd", {22'd0, 1'b1, 8'h07, 1'b0}, 10, 0, 1'b0);
`endif
    tick();
    check_idle("par odd end");
    parity_en  = 1'b0;
    parity_odd = 1'b0;

    // Fill with ticks held off, then overflow
    for (int i = 0; i < 16; i++) write8(8'h10 + 8'(i));
    check("fill level", level, 5'd16);
    check("fill full", full, 1'b1);
    data  = 8'hEE;
    tx_en = 1'b1;
    @(negedge clk);
    check("ovf pulse", overflow, 1'b1);
    cyc();
    tx_en = 1'b0;
    @(negedge clk);
    check("ovf clear", overflow, 1'b0);
    check("ovf level", level, 5'd16);
    cyc();

    // Drain; write on the full-pop tick is dropped, write on the next pop tick is kept
    for (int f = 0; f < 17; f++) begin
      byte_v = (f < 16) ? 8'h10 + 8'(f) : 8'h5A;
      if (f < 2) begin
        data     = (f == 0) ? 8'hDD : 8'h5A;
        tx_en    = 1'b1;
        clk_uart = 1'b1;
        @(negedge clk);
        check($sformatf("pop-write%0d ovf", f), overflow, (f == 0) ? 1'b1 : 1'b0);
        cyc();
        tx_en    = 1'b0;
        clk_uart = 1'b0;
        check($sformatf("pop-write%0d level", f), level, 5'd15);
        check($sformatf("pop-write%0d start", f), TXD, 1'b0);
        cyc();
        send_frame($sformatf("drain%0d", f), {22'd0, 1'b1, byte_v, 1'b0}, 10, 1, 1'b0);
      end else begin
        send_frame($sformatf("drain%0d", f), {22'd0, 1'b1, byte_v, 1'b0}, 10, 0, 1'b0);
      end
    end
    tick();
    check_idle("drain end");
    check("drain empty", empty, 1'b1);

    // DATA_W = 5 instance
    data5  = 5'h15;
    tx_en5 = 1'b1;
    cyc();
    tx_en5 = 1'b0;
    check("w5 level", level5, 5'd1);
    send_frame("w5", {25'd0, 1'b1, 5'h15, 1'b0}, 7, 0, 1'b1);
    tick();
    check("w5 end busy", busy5, 1'b0);
    check("w5 end bps_en", bps_en5, 1'b0);
    check("w5 end TXD", TXD5, 1'b1);

    // One-cycle reset in the middle of the data bits
    write8(8'h96);
    write8(8'h69);
    repeat (3) tick();
    check("mid busy", busy, 1'b1);
    check("mid level", level, 5'd1);
    RSTn = 1'b0;
    cyc();
    RSTn = 1'b1;
    check("mid rst TXD", TXD, 1'b1);
    check("mid rst level", level, 5'd0);
    check("mid rst busy", busy, 1'b0);
    check("mid rst bps_en", bps_en, 1'b0);
    check("mid rst empty", empty, 1'b1);
    write8(8'h4B);
    send_frame("post rst", {22'd0, 1'b1, 8'h4B, 1'b0}, 10, 0, 1'b0);
    tick();
    check_idle("post rst end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised next-generation UART transmitter with an internal write FIFO, selectable stop-bit count and back-to-back framing. It sits between the APB/AHB UART register block and the TXD pin. It uses the shared baud generator: the block raises bps_en and consumes its one-cycle clk_uart tick. Data width, FIFO depth and (optionally) parity are generalised.

Parameters:
DATA_W, 8, data bits per frame (legal 5..8), sent LSB first
FIFO_DEPTH, 16, TX FIFO entries (power of two, >=2)
LVL_W, $clog2(FIFO_DEPTH+1), width of the level output

Ports:
clk  in  1  system clock
RSTn  in  1  synchronous active-low reset
clk_uart  in  1  baud tick, one clk cycle wide, valid only while bps_en=1
data  in  DATA_W  byte to enqueue
tx_en  in  1  write strobe; accepted iff full=0 in the same cycle
stop2  in  1  1 = two stop bits, 0 = one; latched at frame start
parity_en  in  1  parity enable (see Optional Feature)
parity_odd  in  1  1 = odd parity, 0 = even
TXD  out  1  serial line, idle high
bps_en  out  1  baud generator enable
full  out  1  FIFO full
empty  out  1  FIFO empty
level  out  LVL_W  FIFO occupancy, 0..FIFO_DEPTH
busy  out  1  frame in progress (state != IDLE)
overflow  out  1  one-cycle pulse when tx_en=1 while full=1; the write is dropped

Behaviour:
- Reset is synchronous on clk while RSTn=0, including mid-frame. Reset values: TXD=1, bps_en=0, full=0, empty=1, level=0, busy=0, overflow=0. FIFO is cleared, FSM goes to IDLE, and the shift register and counters are zeroed.
- FIFO write: tx_en & ~full pushes data. The entry is visible (empty=0) on the next cycle.
- Write to a full FIFO is dropped even if a pop occurs in the same cycle. Simultaneous push and pop when not full leaves level unchanged.
- bps_en = busy | ~empty, combinational from registered state.
- TXD is registered and changes only on cycles with clk_uart=1. Each bit lasts one tick interval.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on tick with empty=0, do all of: TXD<=0, pop FIFO, load shift register, latch stop2/parity config, clear bit count; go to START. Otherwise TXD holds 1.
- START: on tick, TXD<=bit0, then go to DATA.
- DATA: on tick:
  - If bitcnt<DATA_W-1, send the next bit and increment bitcnt.
  - Otherwise go to PARITY if parity is enabled, with TXD<=parity bit.
  - Otherwise go to STOP with TXD<=1 and stopcnt=0.
- PARITY: on tick, TXD<=1 and go to STOP.
- STOP: on tick:
  - If the latched stop2=1 and stopcnt=0, set stopcnt=1 and stay in STOP.
  - Otherwise, if empty=0, start the next frame directly: same actions as the IDLE start, state START, no idle gap.
  - Otherwise go to IDLE.
- Frame length in ticks: 1 + DATA_W + P + (1 or 2).
- Parity bit: even = XOR of data bits; odd = its inverse.
- For DATA_W<8, upper data bits are not stored.
- stop2/parity changes mid-frame affect only the next frame.
- Ticks arriving in IDLE with empty=1 are ignored.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: the PARITY state exists; parity_en/parity_odd are honoured, latched at frame start.
- Undefined: no PARITY state and no parity logic. parity_en/parity_odd remain ports but are ignored, and frames never contain a parity bit.

Decomposition:
- Package uart_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP), UART_IDLE_LVL=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
- Sub-module uart_tx_fifo (DATA_W, FIFO_DEPTH): synchronous FIFO with pointer-based full/empty/level and the same synchronous active-low reset. The top holds the FSM, shift register, bit/stop counters and parity.

Test Plan:
- Reset, then write 8'hA5 with stop2=0 and parity off → after first tick TXD sequence is 0,1,0,1,0,0,1,0,1,1 (10 ticks). Then busy=0, bps_en=0, TXD=1.
- Write 8'h3C, 8'hC3 back-to-back, stop2=1 → 11-tick frames. The start bit of the second frame immediately follows the second stop bit, with no idle tick.
- With UART_TX_PARITY_EN defined, parity_en=1: write 8'h07 with parity_odd=0 → parity bit 1; with parity_odd=1 → parity bit 0. With the macro undefined, the same stimulus gives a 10-tick frame.
- Hold ticks off and write 17 bytes → level=16, full=1 after 16 writes. The 17th write gives overflow=1 for one cycle and the byte is discarded. Draining sends the first 16 bytes in order.
- DATA_W=5: write 5'h15 → data bits 1,0,1,0,1, 7-tick frame.
- Assert RSTn=0 for one clk mid-DATA → next cycle TXD=1, level=0, busy=0, bps_en=0. A subsequent write transmits normally.
